// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs RV32I field bundles into instruction words and writes them sequentially into IMEM.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_fn3,
    input  logic [6:0]        in_fn7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_illegal;
    logic              w_write;
    logic              w_shift;
    logic [ADDR_W:0]   w_count_inc;
    logic [31:0]       w_enc;
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_illegal   = (in_fmt >= 3'd6) || ((in_fmt == 3'd3 || in_fmt == 3'd5) && in_imm[0]);
        w_write     = w_accept && !w_illegal;
        w_shift     = (in_fn3 == 3'b001) || (in_fn3 == 3'b101);
        w_count_inc = count + 1'b1;
    end
    always_comb begin
        w_enc = in_fmt == 3'd0 ? {in_fn7, in_rs2, in_rs1, in_fn3, in_rd, in_opcode}
              : in_fmt == 3'd1 ? (w_shift ? {in_fn7, in_imm[4:0], in_rs1, in_fn3, in_rd, in_opcode}
                                          : {in_imm[11:0], in_rs1, in_fn3, in_rd, in_opcode})
              : in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_fn3, in_imm[4:0], in_opcode}
              : in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_fn3, in_imm[4:1], in_imm[11], in_opcode}
              : in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode}
              : {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    // the word that fills the last slot is still written; only a missing in_last turns it into an error
    always_comb begin
        w_next = start     ? S_LOAD
               : !w_accept ? r_state
               : w_illegal ? S_ERR
               : in_last   ? S_DONE
               : (w_count_inc == DEPTH_C) ? S_ERR : S_LOAD;
    end
    always_comb begin
        in_ready = (r_state == S_LOAD) && (count < DEPTH_C) && !start;
        busy     = r_state == S_LOAD;
        done     = r_state == S_DONE;
        err      = r_state == S_ERR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
        end else begin
            imem_wen <= w_write;
            if (start) begin
                count <= '0;
            end else if (w_write) begin
                imem_addr  <= BASE_C + count[ADDR_W-1:0];
                imem_wdata <= w_enc;
                count      <= w_count_inc;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and randomized checks of two loaders (DEPTH 256 and 4) against a field-level model.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [2:0]  in_fmt, in_fn3;
    logic [6:0]  in_opcode, in_fn7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        rdy [2];
    logic        wen [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic [8:0]  cnt [2];
    int          total = 0;
    int          bad = 0;
    int          m_mode [2];
    int          m_cnt [2];
    int          m_addr [2];
    logic [31:0] m_wdata [2];
    bit          m_wen [2];
    bit          exp_rdy [2];
    bit          obs_rdy [2];

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) u_big (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_fn3(in_fn3), .in_fn7(in_fn7), .in_imm(in_imm), .in_last(in_last),
        .imem_wen(wen[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .count(cnt[0]));

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_fn3(in_fn3), .in_fn7(in_fn7), .in_imm(in_imm), .in_last(in_last),
        .imem_wen(wen[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .count(cnt[1]));

    function automatic int dep(input int k);
        return k ? 4 : 256;
    endfunction

    function automatic int b(input logic [31:0] x, input int hi, input int lo);
        return int'((x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
    endfunction

    // reference encoding assembled arithmetically from the field placement rules
    function automatic logic [31:0] enc(input int fmt, input int op, input int rd, input int rs1,
                                        input int rs2, input int fn3, input int fn7, input logic [31:0] imm);
        int mid;
        mid = (rs1 << 15) | (fn3 << 12);
        case (fmt)
            0: return 32'((fn7 << 25) | (rs2 << 20) | mid | (rd << 7) | op);
            1: return 32'(((fn3 == 1 || fn3 == 5) ? ((fn7 << 25) | (b(imm, 4, 0) << 20)) : (b(imm, 11, 0) << 20))
                          | mid | (rd << 7) | op);
            2: return 32'((b(imm, 11, 5) << 25) | (rs2 << 20) | mid | (b(imm, 4, 0) << 7) | op);
            3: return 32'((b(imm, 12, 12) << 31) | (b(imm, 10, 5) << 25) | (rs2 << 20) | mid
                          | (b(imm, 4, 1) << 8) | (b(imm, 11, 11) << 7) | op);
            4: return 32'((b(imm, 31, 12) << 12) | (rd << 7) | op);
            default: return 32'((b(imm, 20, 20) << 31) | (b(imm, 10, 1) << 21) | (b(imm, 11, 11) << 20)
                                | (b(imm, 19, 12) << 12) | (rd << 7) | op);
        endcase
    endfunction

    task automatic set_f(input int fmt, input int op, input int rd, input int rs1, input int rs2,
                         input int fn3, input int fn7, input logic [31:0] imm);
        in_fmt = 3'(fmt); in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_fn3 = 3'(fn3); in_fn7 = 7'(fn7); in_imm = imm;
    endtask

    task automatic set_rand();
        int fmt;
        fmt = ($urandom % 16 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
        set_f(fmt, int'($urandom % 128), int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
              int'($urandom % 8), int'($urandom % 128), $urandom);
        if ((fmt == 3 || fmt == 5) && ($urandom % 8 != 0)) in_imm[0] = 1'b0;
    endtask

    // drives one cycle of control inputs and advances the model of both loaders; ends 1 time unit after the edge
    task automatic cyc(input bit r, input bit st, input bit v, input bit last);
        bit illegal;
        rst = r; start = st; in_valid = v; in_last = last;
        #1;
        illegal = (in_fmt >= 6) || ((in_fmt == 3 || in_fmt == 5) && in_imm[0]);
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = (m_mode[k] == 1) && (m_cnt[k] < dep(k)) && !st;
            obs_rdy[k] = rdy[k];
            m_wen[k] = 1'b0;
            if (r) begin
                m_mode[k] = 0; m_cnt[k] = 0; m_addr[k] = 0; m_wdata[k] = '0;
            end else if (st) begin
                m_mode[k] = 1; m_cnt[k] = 0;
            end else if (v && exp_rdy[k]) begin
                if (illegal) m_mode[k] = 3;
                else begin
                    m_wen[k] = 1'b1;
                    m_addr[k] = m_cnt[k];
                    m_wdata[k] = enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_fn3, in_fn7, in_imm);
                    m_cnt[k]++;
                    m_mode[k] = last ? 2 : (m_cnt[k] == dep(k)) ? 3 : 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_f(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            total++; if (wen[k] !== 1'b0) begin bad++; $display("FAIL reset_wen k=%0d got=%b exp=0", k, wen[k]); end
            total++; if (addr[k] !== 8'd0) begin bad++; $display("FAIL reset_addr k=%0d got=%h exp=0", k, addr[k]); end
            total++; if (wdata[k] !== 32'd0) begin bad++; $display("FAIL reset_wdata k=%0d got=%h exp=0", k, wdata[k]); end
            total++; if (cnt[k] !== 9'd0) begin bad++; $display("FAIL reset_count k=%0d got=%0d exp=0", k, cnt[k]); end
            total++; if ({rdy[k], busy[k], done[k], err[k]} !== 4'b0000)
                begin bad++; $display("FAIL reset_flags k=%0d got=%b exp=0000", k, {rdy[k], busy[k], done[k], err[k]}); end
        end
    endtask

    task automatic test_r_type();
        cyc(0, 1, 0, 0);
        set_f(0, 7'h33, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b1) begin bad++; $display("FAIL r_wen got=%b exp=1", wen[0]); end
        total++; if (addr[0] !== 8'd0) begin bad++; $display("FAIL r_addr got=%h exp=0", addr[0]); end
        total++; if (wdata[0] !== 32'h002081B3) begin bad++; $display("FAIL r_wdata got=%h exp=002081b3", wdata[0]); end
        cyc(0, 0, 0, 0);
        total++; if (wen[0] !== 1'b0) begin bad++; $display("FAIL r_wen_pulse got=%b exp=0", wen[0]); end
    endtask

    task automatic test_back_to_back();
        cyc(0, 1, 0, 0);
        set_f(1, 7'h13, 1, 0, 0, 0, 0, 5);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b1 || addr[0] !== 8'd0 || wdata[0] !== 32'h00500093)
            begin bad++; $display("FAIL b2b_first got=%b/%h/%h exp=1/00/00500093", wen[0], addr[0], wdata[0]); end
        set_f(2, 7'h23, 0, 1, 2, 2, 0, 8);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b1 || addr[0] !== 8'd1 || wdata[0] !== 32'h0020A423)
            begin bad++; $display("FAIL b2b_second got=%b/%h/%h exp=1/01/0020a423", wen[0], addr[0], wdata[0]); end
        total++; if (cnt[0] !== 9'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", cnt[0]); end
    endtask

    task automatic test_b_u_j();
        cyc(0, 1, 0, 0);
        set_f(3, 7'h63, 0, 1, 2, 0, 0, 8);
        cyc(0, 0, 1, 0);
        total++; if (wdata[0] !== 32'h00208463) begin bad++; $display("FAIL b_wdata got=%h exp=00208463", wdata[0]); end
        set_f(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
        cyc(0, 0, 1, 0);
        total++; if (wdata[0] !== 32'h123452B7) begin bad++; $display("FAIL u_wdata got=%h exp=123452b7", wdata[0]); end
        set_f(5, 7'h6F, 1, 0, 0, 0, 0, 16);
        cyc(0, 0, 1, 1);
        total++; if (wdata[0] !== 32'h010000EF || addr[0] !== 8'd2)
            begin bad++; $display("FAIL j_wdata got=%h@%h exp=010000ef@02", wdata[0], addr[0]); end
        total++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL j_done got=%b%b exp=10", done[0], busy[0]); end
        cyc(0, 0, 1, 0);
        total++; if (obs_rdy[0] !== 1'b0 || wen[0] !== 1'b0)
            begin bad++; $display("FAIL done_hold rdy/wen got=%b%b exp=00", obs_rdy[0], wen[0]); end
    endtask

    task automatic test_illegal();
        cyc(0, 1, 0, 0);
        set_f(0, 7'h33, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0);
        set_f(3, 7'h63, 0, 1, 2, 0, 0, 3);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b0 || err[0] !== 1'b1 || cnt[0] !== 9'd1)
            begin bad++; $display("FAIL illegal_b got=%b/%b/%0d exp=0/1/1", wen[0], err[0], cnt[0]); end
        cyc(0, 1, 0, 0);
        total++; if (busy[0] !== 1'b1 || cnt[0] !== 9'd0) begin bad++; $display("FAIL restart got=%b/%0d exp=1/0", busy[0], cnt[0]); end
        set_f(6, 7'h33, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b0 || err[0] !== 1'b1) begin bad++; $display("FAIL illegal_fmt got=%b/%b exp=0/1", wen[0], err[0]); end
        cyc(0, 1, 0, 0);
        set_f(0, 7'h33, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0);
        total++; if (wen[0] !== 1'b1 || addr[0] !== 8'd0) begin bad++; $display("FAIL after_err got=%b@%h exp=1@00", wen[0], addr[0]); end
    endtask

    task automatic test_overflow();
        int writes = 0;
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            set_f(1, 7'h13, i + 1, 0, 0, 0, 0, i);
            cyc(0, 0, 1, 0);
            if (wen[1]) begin
                total++; if (addr[1] !== 8'(writes)) begin bad++; $display("FAIL ovf_addr got=%h exp=%h", addr[1], 8'(writes)); end
                writes++;
            end
            if (i == 3) begin
                total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", err[1]); end
            end
        end
        total++; if (writes != 4) begin bad++; $display("FAIL ovf_writes got=%0d exp=4", writes); end
        total++; if (obs_rdy[1] !== 1'b0 || cnt[1] !== 9'd4) begin bad++; $display("FAIL ovf_fifth got=%b/%0d exp=0/4", obs_rdy[1], cnt[1]); end
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_f(1, 7'h13, i + 1, 0, 0, 0, 0, i);
            cyc(0, 0, 1, i == 3);
        end
        total++; if (done[1] !== 1'b1 || err[1] !== 1'b0) begin bad++; $display("FAIL exact_fit got=%b/%b exp=1/0", done[1], err[1]); end
    endtask

    task automatic test_abort_and_rst();
        cyc(0, 1, 0, 0);
        set_f(0, 7'h33, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        total++; if (obs_rdy[0] !== 1'b0 || wen[0] !== 1'b0 || cnt[0] !== 9'd0 || busy[0] !== 1'b1)
            begin bad++; $display("FAIL abort got=%b/%b/%0d/%b exp=0/0/0/1", obs_rdy[0], wen[0], cnt[0], busy[0]); end
        cyc(0, 0, 1, 0);
        total++; if (addr[0] !== 8'd0 || wen[0] !== 1'b1) begin bad++; $display("FAIL abort_addr got=%b@%h exp=1@00", wen[0], addr[0]); end
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        total++; if (wen[0] !== 1'b0 || busy[0] !== 1'b0 || cnt[0] !== 9'd0 || addr[0] !== 8'd0 || wdata[0] !== 32'd0)
            begin bad++; $display("FAIL rst_mid got=%b/%b/%0d/%h/%h exp=0/0/0/00/0", wen[0], busy[0], cnt[0], addr[0], wdata[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            set_rand();
            cyc(0, $urandom % 40 == 0, $urandom % 3 != 0, $urandom % 30 == 0);
            for (int k = 0; k < 2; k++) begin
                total++; if (obs_rdy[k] !== exp_rdy[k]) begin bad++; $display("FAIL rnd_rdy k=%0d i=%0d got=%b exp=%b", k, i, obs_rdy[k], exp_rdy[k]); end
                total++; if (wen[k] !== m_wen[k]) begin bad++; $display("FAIL rnd_wen k=%0d i=%0d got=%b exp=%b", k, i, wen[k], m_wen[k]); end
                total++; if (addr[k] !== 8'(m_addr[k])) begin bad++; $display("FAIL rnd_addr k=%0d i=%0d got=%h exp=%h", k, i, addr[k], 8'(m_addr[k])); end
                total++; if (wdata[k] !== m_wdata[k]) begin bad++; $display("FAIL rnd_wdata k=%0d i=%0d got=%h exp=%h", k, i, wdata[k], m_wdata[k]); end
                total++; if (cnt[k] !== 9'(m_cnt[k])) begin bad++; $display("FAIL rnd_count k=%0d i=%0d got=%0d exp=%0d", k, i, cnt[k], m_cnt[k]); end
                total++; if ({busy[k], done[k], err[k]} !== {m_mode[k] == 1, m_mode[k] == 2, m_mode[k] == 3})
                    begin bad++; $display("FAIL rnd_state k=%0d i=%0d got=%b exp_mode=%0d", k, i, {busy[k], done[k], err[k]}, m_mode[k]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_b_u_j();
        test_illegal();
        test_overflow();
        test_abort_and_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
